// File: rtl/ppc_pkg.sv
// Shared PPC definitions: architectural widths and fetch-queue entry layout.
package ppc_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned MADDR_W = 61;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [ILEN-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fq_entry_t;

endpackage

// File: rtl/ppc_fq_store.sv
// Fetch-queue entry storage: DEPTH x fq_entry_t registers, two write ports
// (tail and tail+1) and one asynchronous read port (head).
module ppc_fq_store
    import ppc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [PW-1:0] waddr0,
    input  fq_entry_t     wdata0,
    input  logic          we1,
    input  logic [PW-1:0] waddr1,
    input  fq_entry_t     wdata1,
    input  logic [PW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    // Entry writes; the two ports always target different slots.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ppc_fetch_queue.sv
// PPC instruction fetch queue: fetches doublewords, splits them into two
// instructions and hands {pc,inst} to the core over valid/ready.
// Optional build macro FQ_PERF_CNT_EN adds fetchCnt/flushCnt counters.
// Bit numbering here is little-endian: PPC bit fpc[61] is fpc[2] below.
module ppc_fetch_queue
    import ppc_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [MADDR_W-1:0] fetchAddr,
    input  logic [XLEN-1:0]    fetchData,
    input  logic               redirValid,
    input  logic [XLEN-1:0]    redirPC,
    output logic               instValid,
    input  logic               instReady,
    output logic [ILEN-1:0]    inst,
    output logic [XLEN-1:0]    instPC
`ifdef FQ_PERF_CNT_EN
    ,
    output logic [31:0]        fetchCnt,
    output logic [31:0]        flushCnt
`endif
);

    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    // Word-aligned fetch PC; the two always-zero bits are not stored.
    logic [XLEN-3:0] fpcW;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;

    logic [PW:0]     need;
    logic            push;
    logic            pop;
    logic [PW:0]     pushN;
    logic [PW:0]     popN;
    pc_t             basePC;
    fq_entry_t       wdata0;
    fq_entry_t       wdata1;
    fq_entry_t       headEntry;
    logic            unusedRedirLo;

    assign unusedRedirLo = ^redirPC[1:0];

    assign fetchAddr = fpcW[XLEN-3:1];
    assign basePC    = {fpcW[XLEN-3:1], 3'b000};

    // Push/pop decisions; free space counts registered entries only.
    always_comb begin
        need  = fpcW[0] ? (PW+1)'(1) : (PW+1)'(2);
        push  = (DEPTH_C - count) >= need;
        pop   = (count != '0) && instReady;
        pushN = push ? need : '0;
        popN  = {{PW{1'b0}}, pop};
    end

    // Entry formation: odd word -> one entry, even word -> two entries.
    always_comb begin
        wdata0 = '0;
        wdata1 = '0;
        if (fpcW[0]) begin
            wdata0.pc   = basePC + 64'd4;
            wdata0.inst = fetchData[31:0];
        end else begin
            wdata0.pc   = basePC;
            wdata0.inst = fetchData[63:32];
            wdata1.pc   = basePC + 64'd4;
            wdata1.inst = fetchData[31:0];
        end
    end

    ppc_fq_store #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_store (
        .clk    (clk),
        .we0    (push),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (push && !fpcW[0]),
        .waddr1 (tail + PW'(1)),
        .wdata1 (wdata1),
        .raddr  (head),
        .rdata  (headEntry)
    );

    assign instValid = (count != '0);
    assign inst      = headEntry.inst;
    assign instPC    = headEntry.pc;

    // Fetch PC, pointers and occupancy; a redirect empties the queue by
    // moving head onto the unchanged tail, dropping any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpcW  <= RESET_PC[XLEN-1:2];
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirValid) begin
            fpcW  <= redirPC[XLEN-1:2];
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                fpcW <= {fpcW[XLEN-3:1] + 61'd1, 1'b0};
                tail <= tail + PW'(need);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + pushN - popN;
        end
    end

`ifdef FQ_PERF_CNT_EN
    // Performance counters: pushed instructions (even if flushed) and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCnt <= '0;
            flushCnt <= '0;
        end else begin
            fetchCnt <= fetchCnt + 32'(pushN);
            if (redirValid) flushCnt <= flushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Self-checking bench for ppc_fetch_queue against a queue-based reference model.
module tb_ppc_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [60:0] fetchAddr;
    logic [63:0] fetchData;
    logic        redirValid = 1'b0;
    logic [63:0] redirPC = '0;
    logic        instValid;
    logic        instReady = 1'b0;
    logic [31:0] inst;
    logic [63:0] instPC;
`ifdef FQ_PERF_CNT_EN
    logic [31:0] fetchCnt;
    logic [31:0] flushCnt;
`endif

    always #5 clk = ~clk;

    ppc_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetchAddr  (fetchAddr),
        .fetchData  (fetchData),
        .redirValid (redirValid),
        .redirPC    (redirPC),
        .instValid  (instValid),
        .instReady  (instReady),
        .inst       (inst),
        .instPC     (instPC)
`ifdef FQ_PERF_CNT_EN
        ,
        .fetchCnt   (fetchCnt),
        .flushCnt   (flushCnt)
`endif
    );

    function automatic logic [63:0] memf(input logic [60:0] a);
        if (a == 61'd0) return 64'h11111111_22222222;
        if (a == 61'd1) return 64'h33333333_44444444;
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    always_comb fetchData = memf(fetchAddr);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mFpc;
    logic [31:0] mFetch;
    logic [31:0] mFlush;
    int          nCmp = 0;
    int          nFail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // One clock: compare outputs with the model, drive inputs, advance model.
    task automatic cycle(input logic r, input logic rv, input logic [63:0] rp, input logic rdy);
        int          need;
        bit          canPush;
        logic [63:0] dw;
        logic [63:0] base;
        @(negedge clk);
        chk("instValid", {63'd0, instValid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instPC", instPC, q[0].pc);
            chk("inst", {32'd0, inst}, {32'd0, q[0].inst});
        end
        chk("fetchAddr", {3'd0, fetchAddr}, mFpc >> 3);
`ifdef FQ_PERF_CNT_EN
        chk("fetchCnt", {32'd0, fetchCnt}, {32'd0, mFetch});
        chk("flushCnt", {32'd0, flushCnt}, {32'd0, mFlush});
`endif
        rst = r; redirValid = rv; redirPC = rp; instReady = rdy;
        if (r) begin
            q.delete();
            mFpc = RESET_PC & ~64'h3;
            mFetch = 0;
            mFlush = 0;
        end else begin
            need = mFpc[2] ? 1 : 2;
            canPush = (int'(DEPTH) - q.size()) >= need;
            dw = memf(mFpc[63:3]);
            base = mFpc & ~64'h7;
            if (canPush) mFetch += 32'(need);
            if (rv) begin
                q.delete();
                mFpc = rp & ~64'h3;
                mFlush++;
            end else begin
                if (rdy && q.size() != 0) void'(q.pop_front());
                if (canPush) begin
                    if (mFpc[2]) begin
                        q.push_back('{base + 64'd4, dw[31:0]});
                    end else begin
                        q.push_back('{base, dw[63:32]});
                        q.push_back('{base + 64'd4, dw[31:0]});
                    end
                    mFpc = base + 64'd8;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // Initial reset (DUT state is unknown before this edge).
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        mFpc = RESET_PC & ~64'h3;
        mFetch = 0;
        mFlush = 0;

        // Fill with core stalled: entries 0,4,8,C then full.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t1_fetchAddrHeld", {3'd0, fetchAddr}, 64'd2);
        chk("t1_headPC", instPC, 64'd0);
        chk("t1_headInst", {32'd0, inst}, 64'h11111111);

        // Drain one with count=4 then stall: push must remain blocked.
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Reset then stream with ready held high.
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Redirect to odd word, then to misaligned target.
        cycle(1'b0, 1'b1, 64'h104, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 64'h203, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 64'h400, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Fetch PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset and redirect together; then three redirects.
        cycle(1'b1, 1'b1, 64'h800, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 64'h40 * (i + 1), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 14) == 0,
                  {$urandom, $urandom},
                  ($urandom % 4) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
